dmem_port_arbiter: RTL

//   Arbitrates the BRAM data port (port B) between the CPU MEM stage (req 0) and the program

---
 rtl/dmem_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares BRAM data port B between the CPU MEM stage and the loader/debug master, with a
// starvation guard, loader lock bursts and tagged routing of read responses to their owner.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_valid,
  output logic                cpu_ready,
  input  logic [DATA_W/8-1:0] cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [DATA_W/8-1:0] ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_wdata,
  input  logic                ld_lock,
  output logic                ld_rvalid,
  output logic [DATA_W-1:0]   ld_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_starve_cnt;
  logic                w_forced;
  logic                w_cpu_gnt;
  logic                w_ld_gnt;
  logic                w_tag_vld;
  logic                w_tag_own;
  logic [RD_LAT-1:0]   r_tag_vld;
  logic [RD_LAT-1:0]   r_tag_own;

  assign w_forced = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    w_state_nxt = r_state;
    w_cpu_gnt   = 1'b0;
    w_ld_gnt    = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (ld_valid && (!cpu_valid || w_forced)) begin
          w_ld_gnt = 1'b1;
          if (ld_lock) w_state_nxt = ST_LOCKED;
        end else begin
          w_cpu_gnt = cpu_valid;
        end
      end
      ST_LOCKED: begin
        w_ld_gnt = ld_valid;
        if (!ld_lock) w_state_nxt = ST_ARB;
      end
      default: w_state_nxt = ST_ARB;
    endcase
    // Grants are masked during reset so that every output, including the muxed bus, reads 0.
    if (!rst_n) begin
      w_cpu_gnt = 1'b0;
      w_ld_gnt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ARB;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!ld_valid || w_ld_gnt) begin
      r_starve_cnt <= '0;
    end else if (!w_forced) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign cpu_ready = w_cpu_gnt;
  assign ld_ready  = w_ld_gnt;
  assign cpu_stall = rst_n & cpu_valid & ~w_cpu_gnt;
  assign mem_en    = w_cpu_gnt | w_ld_gnt;

  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  assign w_tag_vld = (w_cpu_gnt && (cpu_we == '0)) || (w_ld_gnt && (ld_we == '0));
  assign w_tag_own = w_ld_gnt;

  if (RD_LAT == 1) begin : g_tag_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_tag_vld <= '0;
        r_tag_own <= '0;
      end else begin
        r_tag_vld <= w_tag_vld;
        r_tag_own <= w_tag_own;
      end
    end
  end else begin : g_tag_latn
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_tag_vld <= '0;
        r_tag_own <= '0;
      end else begin
        r_tag_vld <= {r_tag_vld[RD_LAT-2:0], w_tag_vld};
        r_tag_own <= {r_tag_own[RD_LAT-2:0], w_tag_own};
      end
    end
  end

  assign cpu_rvalid = r_tag_vld[RD_LAT-1] & ~r_tag_own[RD_LAT-1];
  assign ld_rvalid  = r_tag_vld[RD_LAT-1] &  r_tag_own[RD_LAT-1];
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ld_rdata   = ld_rvalid  ? mem_rdata : '0;

endmodule
